// File: rtl/ref_ramp_sequencer.sv
// Multi-channel action-to-reference sequencer: maps action codes through a
// programmable setpoint table to per-channel targets and slews each reference
// toward its target by a programmable step on a divided update tick.
module ref_ramp_sequencer #(
  parameter int N_CH     = 4,
  parameter int W        = 16,
  parameter int ACT_W    = 3,
  parameter int STEP_DEF = 16,
  parameter int TICK_DIV = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*ACT_W-1:0] action_in,
  input  logic                  action_valid,
  input  logic                  estop,
  input  logic                  cfg_we,
  input  logic [ACT_W-1:0]      cfg_addr,
  input  logic signed [W-1:0]   cfg_data,
  input  logic                  step_we,
  input  logic [W-2:0]          step_data,
  output logic [N_CH*W-1:0]     ref_out,
  output logic                  ref_valid,
  output logic [N_CH-1:0]       at_target,
  output logic                  busy
);

  localparam int DEPTH = 2**ACT_W;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [W:0] STEP_MAX = (W+1)'(2**(W-1) - 1);

  logic signed [W-1:0] tbl_q [DEPTH];
  logic [W-2:0]        step_q;
  logic [CNT_W-1:0]    cnt_q;
  logic signed [W-1:0] ref_q [N_CH];
  logic signed [W-1:0] ref_d [N_CH];
  logic signed [W-1:0] tgt_q [N_CH];
  logic signed [W-1:0] tgt_d [N_CH];
  logic [N_CH-1:0]     at_q, at_d;
  logic                vld_q;
  logic                tick;
  logic [W-2:0]        step_eff;

  // During an emergency stop the ramp runs four times faster, capped at the
  // largest positive step so the step still fits its W-1 bit field.
  function automatic logic [W-2:0] eff_step(input logic [W-2:0] s, input logic stop);
    logic [W:0] s4;
    s4 = {s, 2'b00};
    if (!stop) return s;
    if (s4 > STEP_MAX) return STEP_MAX[W-2:0];
    return s4[W-2:0];
  endfunction

  // One slew step toward the target; the difference is taken one bit wider so
  // full-scale moves neither overflow nor overshoot. A zero step snaps.
  function automatic logic signed [W-1:0] slew(input logic signed [W-1:0] r,
                                               input logic signed [W-1:0] t,
                                               input logic [W-2:0] s);
    logic signed [W:0] diff;
    logic signed [W:0] mag;
    diff = {t[W-1], t} - {r[W-1], r};
    mag  = (diff < 0) ? -diff : diff;
    if (s == '0) return t;
    if (mag <= $signed({2'b00, s})) return t;
    if (diff < 0) return r - $signed({1'b0, s});
    return r + $signed({1'b0, s});
  endfunction

  // Next-state for tick, references, targets and at-target flags.
  always_comb begin
    tick     = (cnt_q == CNT_LAST);
    step_eff = eff_step(step_q, estop);
    for (int k = 0; k < N_CH; k++) begin
      ref_d[k] = tick ? slew(ref_q[k], tgt_q[k], step_eff) : ref_q[k];
      if (estop)
        tgt_d[k] = '0;
      else if (action_valid)
        tgt_d[k] = tbl_q[action_in[k*ACT_W +: ACT_W]];
      else
        tgt_d[k] = tgt_q[k];
      at_d[k] = (ref_d[k] == tgt_d[k]);
    end
  end

  // Setpoint table and slew step configuration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
      tbl_q[1] <= W'(1000);
      tbl_q[2] <= W'(-500);
      step_q   <= (W-1)'(STEP_DEF);
    end else begin
      if (cfg_we)  tbl_q[cfg_addr] <= cfg_data;
      if (step_we) step_q <= step_data;
    end
  end

  // Free-running update tick divider and the output-valid strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
      vld_q <= tick;
    end
  end

  // Per-channel reference, target and at-target state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) begin
        ref_q[k] <= '0;
        tgt_q[k] <= '0;
      end
      at_q <= '1;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        ref_q[k] <= ref_d[k];
        tgt_q[k] <= tgt_d[k];
      end
      at_q <= at_d;
    end
  end

  // Pack the per-channel references onto the output bus.
  always_comb begin
    ref_out = '0;
    for (int k = 0; k < N_CH; k++) ref_out[k*W +: W] = ref_q[k];
  end

  assign ref_valid = vld_q;
  assign at_target = at_q;
  assign busy      = ~&at_q;

endmodule
